// File: rtl/lane_tx_scheduler_if.sv
// Requester-side byte interface shared by the two sources feeding the lane scheduler.
// Handshake: a byte on data_x moves on a rising clk_4f edge where req_x and ready_x are both high;
// data_x must be stable while req_x is high, and ready_x is a same-cycle combinational grant.
interface lane_tx_scheduler_if;
  logic       req_0;
  logic       req_1;
  logic [7:0] data_0;
  logic [7:0] data_1;
  logic       ready_0;
  logic       ready_1;

  modport master (
    output req_0, req_1, data_0, data_1,
    input  ready_0, ready_1
  );

  modport slave (
    input  req_0, req_1, data_0, data_1,
    output ready_0, ready_1
  );
endinterface

// File: rtl/lane_tx_scheduler.sv
// Byte-lane transmit scheduler: COM training, round-robin merge of two requesters,
// periodic SKP insertion, registered symbol output toward the serializer.
module lane_tx_scheduler #(
  parameter int TRAIN_LEN    = 16,
  parameter int SKP_INTERVAL = 64
) (
  input  logic                clk_4f,
  input  logic                reset,
  input  logic                enable,
  lane_tx_scheduler_if.slave  req_if,
  output logic [7:0]          data_out,
  output logic                valid_out,
  output logic                k_out,
  output logic                link_up,
  output logic [1:0]          dbg_state
);

  localparam int TW = $clog2(TRAIN_LEN + 1);
  localparam int SW = $clog2(SKP_INTERVAL);
  localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_LEN - 1);
  localparam logic [SW-1:0] SKP_LAST   = SW'(SKP_INTERVAL - 1);
  localparam logic [7:0]    SYM_COM    = 8'hBC;
  localparam logic [7:0]    SYM_SKP    = 8'h1C;

  typedef enum logic [1:0] {S_IDLE, S_TRAIN, S_ACTIVE, S_SKP} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] train_cnt;
  logic [SW-1:0] skp_cnt;
  logic          last_grant;
  logic          skp_slot, can_grant, grant_0, grant_1, xfer;
  logic [7:0]    xfer_data;
  logic [7:0]    data_nxt;
  logic          valid_nxt, k_nxt, link_nxt;

  assign dbg_state = state;

  // The last ACTIVE slot before SKP is reserved so the SKP boundary never splits a transfer.
  assign skp_slot  = (state == S_ACTIVE) && (skp_cnt == SKP_LAST);
  assign can_grant = (state == S_ACTIVE) && !skp_slot;
  assign grant_0   = req_if.req_0 && (!req_if.req_1 || last_grant);
  assign grant_1   = req_if.req_1 && (!req_if.req_0 || !last_grant);
  assign req_if.ready_0 = can_grant && grant_0;
  assign req_if.ready_1 = can_grant && grant_1;
  assign xfer      = req_if.ready_0 || req_if.ready_1;
  assign xfer_data = req_if.ready_1 ? req_if.data_1 : req_if.data_0;

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   state_nxt = S_TRAIN;
        S_TRAIN:  if (train_cnt == TRAIN_LAST) state_nxt = S_ACTIVE;
        S_ACTIVE: if (skp_slot) state_nxt = S_SKP;
        S_SKP:    state_nxt = S_ACTIVE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    data_nxt  = SYM_COM;
    valid_nxt = 1'b0;
    k_nxt     = 1'b1;
    link_nxt  = 1'b0;
    if (enable) begin
      case (state)
        S_TRAIN: valid_nxt = 1'b1;
        S_ACTIVE: begin
          link_nxt = 1'b1;
          if (xfer) begin
            data_nxt  = xfer_data;
            valid_nxt = 1'b1;
            k_nxt     = 1'b0;
          end
        end
        S_SKP: begin
          data_nxt  = SYM_SKP;
          valid_nxt = 1'b1;
          link_nxt  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      data_out  <= SYM_COM;
      valid_out <= 1'b0;
      k_out     <= 1'b1;
      link_up   <= 1'b0;
    end else begin
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
      k_out     <= k_nxt;
      link_up   <= link_nxt;
    end
  end

  // The SKP cycle itself counts as a slot, so steady-state SKPs are SKP_INTERVAL cycles apart.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      train_cnt  <= '0;
      skp_cnt    <= '0;
      last_grant <= 1'b1;
    end else begin
      if (xfer) last_grant <= req_if.ready_1;
      if (!enable || state != S_TRAIN || train_cnt == TRAIN_LAST) train_cnt <= '0;
      else                                                        train_cnt <= train_cnt + TW'(1);
      if (!enable || skp_slot)                           skp_cnt <= '0;
      else if (state == S_ACTIVE || state == S_SKP)      skp_cnt <= skp_cnt + SW'(1);
      else                                               skp_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_lane_tx_scheduler.sv
// Directed bench for lane_tx_scheduler: training, arbitration table, SKP spacing,
// held request across SKP, enable drop and mid-training reset.
module tb_lane_tx_scheduler;
  localparam int TRAIN_LEN    = 16;
  localparam int SKP_INTERVAL = 64;
  localparam int N_VEC        = 14;
  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] SKP  = 8'h1C;

  typedef struct {
    logic       r0, r1;
    logic [7:0] d0, d1;
    logic       er0, er1;
    logic [7:0] ed;
    logic       ev, ek;
  } vec_t;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] data_out;
  logic       valid_out, k_out, link_up;
  logic [1:0] dbg_state;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  vec_t       vecs[N_VEC];
  int         pos;
  logic [7:0] seq;
  logic       exp_rdy, in_skp;

  lane_tx_scheduler_if rif();

  lane_tx_scheduler #(.TRAIN_LEN(TRAIN_LEN), .SKP_INTERVAL(SKP_INTERVAL)) dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .enable    (enable),
    .req_if    (rif),
    .data_out  (data_out),
    .valid_out (valid_out),
    .k_out     (k_out),
    .link_up   (link_up),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk_4f = ~clk_4f;

  task automatic step();
    @(posedge clk_4f);
    #1;
  endtask

  // driver
  task automatic drive(input logic r0, input logic r1, input logic [7:0] d0, input logic [7:0] d1);
    rif.req_0  = r0;
    rif.req_1  = r1;
    rif.data_0 = d0;
    rif.data_1 = d1;
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] d, input logic v,
                           input logic k, input logic l);
    check({name, ".data"},    32'(data_out),  32'(d));
    check({name, ".valid"},   32'(valid_out), 32'(v));
    check({name, ".k"},       32'(k_out),     32'(k));
    check({name, ".link_up"}, 32'(link_up),   32'(l));
  endtask

  task automatic check_rdy(input string name, input logic r0, input logic r1);
    check({name, ".ready_0"}, 32'(rif.ready_0), 32'(r0));
    check({name, ".ready_1"}, 32'(rif.ready_1), 32'(r1));
  endtask

  // Starts from IDLE: one IDLE output, then n COM training bytes, requests held high throughout.
  task automatic train(input int n);
    enable = 1'b1;
    drive(1'b1, 1'b1, 8'h11, 8'h22);
    #1;
    check_rdy("idle_rdy", 1'b0, 1'b0);
    step();
    check_out("idle_out", COM, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      check_rdy($sformatf("train%0d_rdy", i), 1'b0, 1'b0);
      step();
      check_out($sformatf("train%0d", i), COM, 1'b1, 1'b1, 1'b0);
    end
  endtask

  task automatic wait_skp(input string name, input int exp_idle);
    int idle = 0;
    bit found = 1'b0;
    for (int i = 0; i < 4 * SKP_INTERVAL && !found; i++) begin
      step();
      if (data_out === SKP) found = 1'b1;
      else if (data_out === COM && valid_out === 1'b0 && k_out === 1'b1 && link_up === 1'b1) idle++;
    end
    check({name, ".found"}, 32'(found), 32'd1);
    check({name, ".idle_count"}, 32'(idle), 32'(exp_idle));
    check_out({name, ".skp"}, SKP, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h11, 8'h22, 1'b0, 1'b0, COM,   1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 8'h33, 8'h44, 1'b0, 1'b1, 8'h44, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h55, 8'h66, 1'b0, 1'b1, 8'h66, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 8'h77, 8'h88, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'h99, 8'hAA, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 8'hA5, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, COM,   1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 8'hC3, 8'hD4, 1'b0, 1'b1, 8'hD4, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, COM,   1'b0, 1'b1};

    reset  = 1'b1;
    enable = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    #2;
    check_out("reset", COM, 1'b0, 1'b1, 1'b0);
    check_rdy("reset_rdy", 1'b0, 1'b0);
    check("reset_state", 32'(dbg_state), 32'd0);
    step();
    reset = 1'b0;

    // link bring-up, then arbitration table starting in the first ACTIVE cycle
    train(TRAIN_LEN);
    for (int i = 0; i < N_VEC; i++) begin
      drive(vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1);
      #1;
      check_rdy($sformatf("vec%0d_rdy", i), vecs[i].er0, vecs[i].er1);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].ed, vecs[i].ev, vecs[i].ek, 1'b1);
    end

    // SKP spacing: first window started with link-up, second is a full steady-state window
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    wait_skp("skp_win1", SKP_INTERVAL - N_VEC);
    wait_skp("skp_win2", SKP_INTERVAL - 1);
    step();
    check_out("after_skp", COM, 1'b0, 1'b1, 1'b1);

    // req_0 held across a SKP slot; pos tracks the slot index, SKP_INTERVAL marks the SKP cycle
    pos = 2;
    seq = 8'h40;
    for (int i = 0; i < 70; i++) begin
      in_skp  = (pos == SKP_INTERVAL);
      exp_rdy = (pos < SKP_INTERVAL - 1);
      drive(1'b1, 1'b0, seq, 8'h00);
      #1;
      check_rdy($sformatf("hold%0d_rdy", i), exp_rdy, 1'b0);
      if (exp_rdy) exp_q.push_back(seq);
      step();
      if (in_skp)       check_out("hold_skp", SKP, 1'b1, 1'b1, 1'b1);
      else if (exp_rdy) check_out("hold_byte", exp_q.pop_front(), 1'b1, 1'b0, 1'b1);
      else              check_out("hold_gap", COM, 1'b0, 1'b1, 1'b1);
      if (exp_rdy) seq = seq + 8'd1;
      pos = in_skp ? 1 : pos + 1;
    end
    check("hold_queue_empty", 32'(exp_q.size()), 32'd0);

    // enable drop while requester 1 transfers: byte discarded but requester 1 counts as served
    enable = 1'b0;
    drive(1'b0, 1'b1, 8'h00, 8'hE7);
    #1;
    check_rdy("drop_rdy", 1'b0, pos < SKP_INTERVAL - 1);
    step();
    check_out("drop_out", COM, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("drop_idle", COM, 1'b0, 1'b1, 1'b0);
    end
    check("drop_state", 32'(dbg_state), 32'd0);
    train(TRAIN_LEN);
    check_rdy("retrain_rdy", 1'b1, 1'b0);
    step();
    check_out("retrain_first", 8'h11, 1'b1, 1'b0, 1'b1);

    // reset mid-training at byte 7; afterwards requester 0 must win the first contest again
    enable = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    step();
    check_out("pre_rst_idle", COM, 1'b0, 1'b1, 1'b0);
    train(7);
    reset = 1'b1;
    #1;
    check_out("rst_mid", COM, 1'b0, 1'b1, 1'b0);
    check_rdy("rst_mid_rdy", 1'b0, 1'b0);
    check("rst_mid_state", 32'(dbg_state), 32'd0);
    step();
    step();
    reset = 1'b0;
    train(TRAIN_LEN);
    check_rdy("post_rst_rdy", 1'b1, 1'b0);
    step();
    check_out("post_rst_first", 8'h11, 1'b1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lane_tx_scheduler.md
LANE_TX_SCHEDULER -- requirements
Module: lane_tx_scheduler

Interface
REQ-001 Parameter TRAIN_LEN, default 16: number of COM training bytes sent before the link is declared up.
REQ-002 Parameter SKP_INTERVAL, default 64: number of ACTIVE-state byte slots between SKP insertions.
REQ-003 clk_4f  input  1  byte clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  link enable; high starts training, low returns the lane to idle.
REQ-006 req_0, req_1  input  1 each  requester byte available.
REQ-007 data_0, data_1  input  8 each  requester byte, valid while the matching req is high.
REQ-008 ready_0, ready_1  output  1 each  combinational grant; a byte transfers on a clock edge where req_x and ready_x are both high.
REQ-009 data_out  output  8  byte to the parallel-to-serial stage, registered.
REQ-010 valid_out  output  1  data_out is to be transmitted as-is, registered.
REQ-011 k_out  output  1  data_out is a control symbol (COM/SKP), registered.
REQ-012 link_up  output  1  high while in ACTIVE or SKP, registered.

Function
REQ-013 The FSM SHALL have states IDLE, TRAIN, ACTIVE and SKP.
REQ-014 IDLE: outputs data_out=8'hBC, valid_out=0, k_out=1; go to TRAIN when enable=1.
REQ-015 TRAIN: each cycle outputs 8'hBC, valid_out=1, k_out=1; train_cnt increments; after the TRAIN_LEN-th COM byte, go to ACTIVE.
REQ-016 ACTIVE: the granted byte appears on data_out one cycle after transfer, with valid_out=1 and k_out=0.
REQ-017 ACTIVE with no transfer: output 8'hBC, valid_out=0, k_out=1 (idle fill).
REQ-018 ACTIVE: skp_cnt increments every cycle; when skp_cnt=SKP_INTERVAL-1, go to SKP and clear skp_cnt.
REQ-019 SKP: lasts exactly one cycle; outputs 8'h1C, valid_out=1, k_out=1; returns to ACTIVE.
REQ-020 ready_0 and ready_1 SHALL be low in IDLE, TRAIN and SKP, and in the ACTIVE cycle where skp_cnt=SKP_INTERVAL-1.
REQ-021 At most one ready SHALL be high in any cycle.
REQ-022 Arbitration is round-robin with a 1-bit last_grant pointer.
- If both req are high, grant the requester not equal to last_grant.
- If one req is high, grant it.
- last_grant updates only on an actual transfer.
REQ-023 With no req high, neither ready is high and last_grant holds.
REQ-024 enable=0 in any state SHALL force IDLE on the next edge and clear train_cnt and skp_cnt.
- A byte transferred on that same edge is discarded.
- The requester is still considered served.
REQ-025 Counters SHALL saturate/clear as specified and never wrap mid-state.
- train_cnt width: clog2(TRAIN_LEN+1).
- skp_cnt width: clog2(SKP_INTERVAL).
REQ-026 link_up SHALL be 1 exactly in the cycles whose registered output originates from ACTIVE or SKP.

Reset
REQ-027 Asserting reset SHALL immediately set the following:
- state=IDLE
- data_out=8'hBC, valid_out=0, k_out=1
- link_up=0
- train_cnt=0, skp_cnt=0
- last_grant=1 (requester 0 wins first contest)
REQ-028 Reset asserted mid-training or mid-transfer SHALL abort with no byte emitted.
- Training restarts from zero after reset release with enable=1.

Verification
REQ-029 Reset release, enable=1, TRAIN_LEN=16 -> 16 consecutive cycles of BC/valid=1/k=1, then link_up=1, ready visible.
REQ-030 ACTIVE, req_0=req_1=1 continuously, data_0=8'h11, data_1=8'h22 -> data_out alternates 11,22,11,22 starting with 11, k_out=0.
REQ-031 ACTIVE, no requests for SKP_INTERVAL cycles -> SKP_INTERVAL-1 idle BC/valid=0, then one 1C/valid=1/k=1, then idle BC resumes.
REQ-032 req_0 held high across a SKP slot -> ready_0 low in the slot cycle, and no byte lost or duplicated.
REQ-033 enable dropped during ACTIVE -> next cycle IDLE outputs, link_up=0; enable re-raised -> full TRAIN_LEN sequence repeats.
REQ-034 reset pulsed at training byte 7 -> outputs immediately BC/valid=0/k=1; after release, 16 fresh COM bytes.
